// File: rtl/a51_key_setup.sv
// A5/1 key/frame mixing front end: absorbs Kc then Fn into R1/R2/R3 with regular
// clocking and offers the mixed 64-bit state downstream over valid/ready.
module a51_key_setup #(
   parameter int BITS_PER_CYCLE = 1,
   parameter int StateWidth     = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [64:1]           kc,
   input  logic [22:1]           fn,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [StateWidth:1]   out_state,
   output logic [1:0]            dbg_state
);

   // Handshake: out_state is offered while out_valid=1 and is consumed on a rising
   // edge where out_valid && out_ready; out_valid and out_state never change while
   // out_valid=1 and out_ready=0.

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_KC = 2'd1,
      LOAD_FN = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [6:0] StepB = 7'(BITS_PER_CYCLE);

   state_t      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [63:0] kc_sh_q, kc_sh_d;
   logic [21:0] fn_sh_q, fn_sh_d;
   logic [63:0] lfsr_q, lfsr_d;
   logic [5:0]  idx;
   logic        bit_in;

   // Packed as {R3[22:0], R2[21:0], R1[18:0]}; one regular clock of all three.
   function automatic logic [63:0] lfsr_step(input logic [63:0] s, input logic b);
      logic [18:0] r1;
      logic [21:0] r2;
      logic [22:0] r3;
      r1 = s[18:0];
      r2 = s[40:19];
      r3 = s[63:41];
      r1 = {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ b};
      r2 = {r2[20:0], r2[20] ^ r2[21] ^ b};
      r3 = {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ b};
      return {r3, r2, r1};
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kc_sh_d = kc_sh_q;
      fn_sh_d = fn_sh_q;
      lfsr_d  = lfsr_q;
      idx     = '0;
      bit_in  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               kc_sh_d = kc;
               fn_sh_d = fn;
               lfsr_d  = '0;
               cnt_d   = '0;
               state_d = LOAD_KC;
            end
         end
         LOAD_KC: begin
            for (int k = 0; k < BITS_PER_CYCLE; k++) begin
               idx    = cnt_q[5:0] + 6'(k);
               bit_in = kc_sh_q[idx];
               lfsr_d = lfsr_step(lfsr_d, bit_in);
            end
            cnt_d = cnt_q + StepB;
            if (cnt_d == 7'd64) begin
               cnt_d   = '0;
               state_d = LOAD_FN;
            end
         end
         LOAD_FN: begin
            for (int k = 0; k < BITS_PER_CYCLE; k++) begin
               idx    = cnt_q[5:0] + 6'(k);
               bit_in = fn_sh_q[idx[4:0]];
               lfsr_d = lfsr_step(lfsr_d, bit_in);
            end
            cnt_d = cnt_q + StepB;
            if (cnt_d == 7'd22) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         kc_sh_q <= '0;
         fn_sh_q <= '0;
         lfsr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kc_sh_q <= kc_sh_d;
         fn_sh_q <= fn_sh_d;
         lfsr_q  <= lfsr_d;
      end
   end

   assign busy      = (state_q == LOAD_KC) || (state_q == LOAD_FN);
   assign out_valid = (state_q == DONE);
   assign out_state = lfsr_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_a51_key_setup.sv
// Bench for a51_key_setup: B=1 and B=2 instances, each checked every cycle against
// a transaction-level A5/1 key-setup model with latency countdown and expected queue.
module tb_a51_key_setup;

   logic        clk;
   logic        rst_s   [2];
   logic        start_s [2];
   logic        ready_s [2];
   logic [64:1] kc_s    [2];
   logic [22:1] fn_s    [2];
   logic        busy_s  [2];
   logic        valid_s [2];
   logic [64:1] st_s    [2];
   logic [1:0]  dbg_s   [2];

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   int          mcnt  [2] = '{0, 0};
   logic        mdone [2] = '{1'b0, 1'b0};
   logic        fresh [2] = '{1'b0, 1'b0};
   logic [63:0] exp_q0 [$];
   logic [63:0] exp_q1 [$];
   logic        lit_en  [2];
   logic [63:0] lit_val [2];
   logic        pins_done = 1'b0;

   a51_key_setup #(.BITS_PER_CYCLE(1)) u_b1 (
      .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .kc(kc_s[0]), .fn(fn_s[0]),
      .busy(busy_s[0]), .out_valid(valid_s[0]), .out_ready(ready_s[0]),
      .out_state(st_s[0]), .dbg_state(dbg_s[0])
   );

   a51_key_setup #(.BITS_PER_CYCLE(2)) u_b2 (
      .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .kc(kc_s[1]), .fn(fn_s[1]),
      .busy(busy_s[1]), .out_valid(valid_s[1]), .out_ready(ready_s[1]),
      .out_state(st_s[1]), .dbg_state(dbg_s[1])
   );

   always #5 clk = ~clk;

   function automatic int lat(input int i);
      return (i == 0) ? 86 : 43;
   endfunction

   // A5/1 key setup from the algorithm: 64 Kc bits then 22 Fn bits, feedback = parity of taps ^ bit
   function automatic logic [63:0] a51_ref(input logic [63:0] k, input logic [21:0] f);
      logic [31:0] r1, r2, r3;
      logic        b;
      r1 = 0; r2 = 0; r3 = 0;
      for (int n = 0; n < 86; n++) begin
         b  = (n < 64) ? k[n] : f[n-64];
         r1 = ((r1 << 1) | {31'b0, (^(r1 & 32'h0007_2000)) ^ b}) & 32'h0007_FFFF;
         r2 = ((r2 << 1) | {31'b0, (^(r2 & 32'h0030_0000)) ^ b}) & 32'h003F_FFFF;
         r3 = ((r3 << 1) | {31'b0, (^(r3 & 32'h0070_0080)) ^ b}) & 32'h007F_FFFF;
      end
      return {r3[22:0], r2[21:0], r1[18:0]};
   endfunction

   task automatic chk(input string name, input int inst, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst=%0d t=%0t: got %h expected %h", name, inst, $time, act, exp);
      end
   endtask

   // behavioural model: transaction accepted in idle, ready after lat() edges, held until handshake
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst_s[i]) begin
            mcnt[i]  = 0;
            mdone[i] = 1'b0;
            fresh[i] = 1'b1;
            if (i == 0) exp_q0.delete(); else exp_q1.delete();
         end else if (mdone[i]) begin
            if (ready_s[i]) begin
               mdone[i] = 1'b0;
               if (i == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            end
         end else if (mcnt[i] != 0) begin
            mcnt[i]--;
            if (mcnt[i] == 0) mdone[i] = 1'b1;
         end else if (start_s[i]) begin
            mcnt[i]  = lat(i);
            fresh[i] = 1'b0;
            if (i == 0) exp_q0.push_back(a51_ref(kc_s[i], fn_s[i]));
            else        exp_q1.push_back(a51_ref(kc_s[i], fn_s[i]));
         end
      end
   end

   // compare process
   always @(negedge clk) begin
      if (!pins_done) begin
         chk("ref_zero", 0, a51_ref(64'h0, 22'h0), 64'h0);
         chk("ref_fn21", 0, a51_ref(64'h0, 22'h200000), 64'h0000_0200_0008_0001);
         chk("ref_fn20", 0, a51_ref(64'h0, 22'h100000), 64'h0000_0400_0010_0002);
         pins_done = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
         chk("busy", i, {63'b0, busy_s[i]}, {63'b0, (mcnt[i] != 0)});
         chk("out_valid", i, {63'b0, valid_s[i]}, {63'b0, mdone[i]});
         if (fresh[i]) chk("reset_state", i, st_s[i], 64'h0);
         if (mdone[i]) begin
            if (i == 0 && exp_q0.size() > 0) chk("out_state", i, st_s[i], exp_q0[0]);
            if (i == 1 && exp_q1.size() > 0) chk("out_state", i, st_s[i], exp_q1[0]);
            if (lit_en[i]) chk("out_state_lit", i, st_s[i], lit_val[i]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input int i, input logic [21:0] f, input logic [63:0] e);
      kc_s[i]    = '0;
      fn_s[i]    = f;
      lit_val[i] = e;
      lit_en[i]  = 1'b1;
      ready_s[i] = 1'b1;
      start_s[i] = 1'b1;
      tick();
      start_s[i] = 1'b0;
      repeat (lat(i) + 3) tick();
      lit_en[i] = 1'b0;
   endtask

   task automatic run_seq(input int i);
      rst_s[i] = 1'b1;
      repeat (3) tick();
      rst_s[i] = 1'b0;
      tick();
      // zero key, then single Fn bit 21, then single Fn bit 20
      directed(i, 22'h0, 64'h0);
      directed(i, 22'h200000, 64'h0000_0200_0008_0001);
      directed(i, 22'h100000, 64'h0000_0400_0010_0002);
      // back-pressure in DONE while start/kc/fn wiggle
      ready_s[i] = 1'b0;
      kc_s[i]    = {$urandom, $urandom};
      fn_s[i]    = 22'($urandom);
      start_s[i] = 1'b1;
      tick();
      start_s[i] = 1'b0;
      repeat (lat(i) + 2) tick();
      repeat (20) begin
         start_s[i] = 1'($urandom_range(0, 1));
         kc_s[i]    = {$urandom, $urandom};
         fn_s[i]    = 22'($urandom);
         tick();
      end
      start_s[i] = 1'b0;
      ready_s[i] = 1'b1;
      repeat (3) tick();
      // reset in the middle of loading, then a clean run
      kc_s[i]    = {$urandom, $urandom};
      fn_s[i]    = 22'($urandom);
      start_s[i] = 1'b1;
      tick();
      start_s[i] = 1'b0;
      repeat (40) tick();
      rst_s[i] = 1'b1;
      tick();
      rst_s[i] = 1'b0;
      tick();
      directed(i, 22'h100000, 64'h0000_0400_0010_0002);
      // random traffic: start pulses (also while busy), random back-pressure, rare reset
      repeat (6000) begin
         rst_s[i]   = ($urandom_range(0, 1999) == 0);
         start_s[i] = ($urandom_range(0, 3) == 0);
         ready_s[i] = ($urandom_range(0, 9) < 7);
         kc_s[i]    = {$urandom, $urandom};
         fn_s[i]    = 22'($urandom);
         tick();
      end
      rst_s[i]   = 1'b0;
      start_s[i] = 1'b0;
      ready_s[i] = 1'b1;
      repeat (lat(i) + 5) tick();
   endtask

   initial begin
      clk = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rst_s[i]   = 1'b1;
         start_s[i] = 1'b0;
         ready_s[i] = 1'b1;
         kc_s[i]    = '0;
         fn_s[i]    = '0;
         lit_en[i]  = 1'b0;
         lit_val[i] = '0;
      end
      tick();
      rst_s[0] = 1'b0;
      run_seq(0);
      run_seq(1);
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
